flt2fix_ctrl: RTL

Sequencer for the half-precision float to signed fixed 8.8 conversion datapath.
- On a start request it reads the 16-bit float from data memory, drives an iterative shift datapath, saturates and applies the sign, then writes the 16-bit result back.
- It acknowledges completion with a one-cycle done pulse.
- It sits between the test-bench/top-level handshake and the shared data_mem port, and is the only master of that port while busy.

---
 rtl/flt2fix_pkg.sv | 26 ++
 rtl/flt2fix_shift_unit.sv | 101 ++++++++++
 rtl/flt2fix_ctrl.sv | 119 +++++++++++
 3 files changed

// File: rtl/flt2fix_pkg.sv
// Shared types and constants for the half-precision float to signed fixed 8.8 converter.
package flt2fix_pkg;

    typedef enum logic [3:0] {
        IDLE,
        RD_LO,
        RD_HI,
        CLASSIFY,
        SHIFT,
        PACK,
        WR_LO,
        WR_HI,
        DONE
    } state_t;

    localparam int unsigned EXP_BIAS  = 15;
    localparam int unsigned FRAC_BITS = 8;
    localparam int unsigned MAN_BITS  = 10;

    // Exponent at which the 11-bit mantissa already sits in 8.8 alignment.
    localparam logic [4:0]  EXP_PIVOT   = 5'(EXP_BIAS + MAN_BITS - FRAC_BITS);
    localparam logic [4:0]  SAT_EXP     = 5'd22;
    localparam logic [15:0] FIX_MAX_POS = 16'h7FFF;
    localparam logic [15:0] FIX_MAX_NEG = 16'h8000;

endpackage

// File: rtl/flt2fix_shift_unit.sv
// Iterative magnitude shifter with classify, saturation and sign application for flt2fix_ctrl.
module flt2fix_shift_unit
    import flt2fix_pkg::*;
#(
    parameter int unsigned MAX_RSH = 12
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        load_i,
    input  logic        step_i,
    input  logic        pack_i,
    input  logic [15:0] flt_i,
    output logic        need_shift_o,
    output logic        shift_last_o,
    output logic [15:0] result_o
);

    localparam logic [4:0] RshCap = 5'(MAX_RSH);

    logic [4:0]  exp_w;
    logic [4:0]  rsh_w;
    logic [4:0]  shcnt_w;
    logic        sat_w;
    logic        left_w;
    logic [15:0] mag15_w;

    logic [16:0] mag_q, mag_d;
    logic [4:0]  shcnt_q, shcnt_d;
    logic        left_q, left_d;
    logic        sat_q, sat_d;
    logic        sign_q, sign_d;
    logic [15:0] result_q, result_d;

    assign exp_w = flt_i[14:10];

    always_comb begin
        sat_w   = exp_w > SAT_EXP;
        left_w  = exp_w >= EXP_PIVOT;
        rsh_w   = EXP_PIVOT - exp_w;
        shcnt_w = '0;
        if (left_w) begin
            // Saturating exponents skip shifting; the result is forced in PACK.
            if (!sat_w) begin
                shcnt_w = exp_w - EXP_PIVOT;
            end
        end else begin
            shcnt_w = (rsh_w > RshCap) ? RshCap : rsh_w;
        end
    end

    assign need_shift_o = (shcnt_w != '0);
    assign shift_last_o = (shcnt_q == 5'd1);
    assign mag15_w      = {1'b0, mag_q[14:0]};

    always_comb begin
        mag_d    = mag_q;
        shcnt_d  = shcnt_q;
        left_d   = left_q;
        sat_d    = sat_q;
        sign_d   = sign_q;
        result_d = result_q;
        if (load_i) begin
            mag_d   = {6'd0, |exp_w, flt_i[9:0]};
            shcnt_d = shcnt_w;
            left_d  = left_w;
            sat_d   = sat_w;
            sign_d  = flt_i[15];
        end else if (step_i) begin
            mag_d   = left_q ? (mag_q << 1) : (mag_q >> 1);
            shcnt_d = shcnt_q - 5'd1;
        end
        if (pack_i) begin
            if (sat_q || (mag_q[16:15] != 2'b00)) begin
                result_d = sign_q ? FIX_MAX_NEG : FIX_MAX_POS;
            end else begin
                result_d = sign_q ? (~mag15_w + 16'd1) : mag15_w;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mag_q    <= '0;
            shcnt_q  <= '0;
            left_q   <= 1'b0;
            sat_q    <= 1'b0;
            sign_q   <= 1'b0;
            result_q <= '0;
        end else begin
            mag_q    <= mag_d;
            shcnt_q  <= shcnt_d;
            left_q   <= left_d;
            sat_q    <= sat_d;
            sign_q   <= sign_d;
            result_q <= result_d;
        end
    end

    assign result_o = result_q;

endmodule

// File: rtl/flt2fix_ctrl.sv
// Sequencer: fetches a half float from data memory, runs the shift unit, writes the 8.8 result.
module flt2fix_ctrl
    import flt2fix_pkg::*;
#(
    parameter logic [7:0]  SRC_ADDR = 8'd4,
    parameter logic [7:0]  DST_ADDR = 8'd6,
    parameter int unsigned MAX_RSH  = 12
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_i,
    output logic       done_o,
    output logic [7:0] dm_addr_o,
    output logic       dm_wr_en_o,
    output logic [7:0] dm_wdata_o,
    input  logic [7:0] dm_rdata_i,
    output logic       busy_o
);

    state_t      state_q, state_d;
    logic        start_q;
    logic [15:0] flt_q, flt_d;
    logic        trigger;
    logic        load, step, pack;
    logic        need_shift, shift_last;
    logic [15:0] result;

    // Conversion launches on the falling edge of start.
    assign trigger = start_q & ~start_i;

    always_comb begin
        state_d    = state_q;
        flt_d      = flt_q;
        dm_addr_o  = 8'd0;
        dm_wr_en_o = 1'b0;
        dm_wdata_o = 8'd0;
        done_o     = 1'b0;
        load       = 1'b0;
        step       = 1'b0;
        pack       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (trigger) begin
                    state_d = RD_LO;
                end
            end
            RD_LO: begin
                dm_addr_o  = SRC_ADDR;
                flt_d[7:0] = dm_rdata_i;
                state_d    = RD_HI;
            end
            RD_HI: begin
                dm_addr_o   = SRC_ADDR + 8'd1;
                flt_d[15:8] = dm_rdata_i;
                state_d     = CLASSIFY;
            end
            CLASSIFY: begin
                load    = 1'b1;
                state_d = need_shift ? SHIFT : PACK;
            end
            SHIFT: begin
                step = 1'b1;
                if (shift_last) begin
                    state_d = PACK;
                end
            end
            PACK: begin
                pack    = 1'b1;
                state_d = WR_LO;
            end
            WR_LO: begin
                dm_addr_o  = DST_ADDR;
                dm_wdata_o = result[7:0];
                dm_wr_en_o = 1'b1;
                state_d    = WR_HI;
            end
            WR_HI: begin
                dm_addr_o  = DST_ADDR + 8'd1;
                dm_wdata_o = result[15:8];
                dm_wr_en_o = 1'b1;
                state_d    = DONE;
            end
            DONE: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy_o = (state_q != IDLE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            start_q <= 1'b0;
            flt_q   <= '0;
        end else begin
            state_q <= state_d;
            start_q <= start_i;
            flt_q   <= flt_d;
        end
    end

    flt2fix_shift_unit #(
        .MAX_RSH(MAX_RSH)
    ) u_shift (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .load_i      (load),
        .step_i      (step),
        .pack_i      (pack),
        .flt_i       (flt_q),
        .need_shift_o(need_shift),
        .shift_last_o(shift_last),
        .result_o    (result)
    );

endmodule
